// File: rtl/acia_pkg.sv
// Shared constants, FSM states and helpers for the ACIA polling host controller.
package acia_pkg;

  localparam int ST_RXF = 0;
  localparam int ST_TXE = 1;
  localparam int ST_ERR = 4;

  localparam logic [7:0] MRESET = 8'h03;

  typedef enum logic [2:0] {
    INIT_RST = 3'd0,
    INIT_CFG = 3'd1,
    POLL     = 3'd2,
    STAT     = 3'd3,
    RX_RD    = 3'd4,
    RX_CAP   = 3'd5,
    TX_WR    = 3'd6,
    GAP      = 3'd7
  } state_t;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/acia_host_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    int j;
    logic hit;
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = 0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j        = (int'(ptr) + k) % N;
      hit      = !any && req[j];
      grant[j] = hit;
      index    = hit ? IW'(j) : index;
      any      = any | hit;
    end
  end

endmodule

// File: rtl/acia_host_ctrl.sv
// Polling bus master for the ACIA: initialises it, polls status, moves RX bytes
// into a holding register and writes TX bytes from round-robin requesters.
module acia_host_ctrl
  import acia_pkg::*;
#(
  parameter int         NREQ     = 2,
  parameter logic [7:0] CTRL_CFG = 8'h14,
  parameter int         POLL_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              acia_cs,
  output logic              acia_we,
  output logic              acia_rs,
  output logic [7:0]        acia_din,
  input  logic [7:0]        acia_dout,
  input  logic [NREQ-1:0]   tx_valid,
  input  logic [NREQ*8-1:0] tx_data,
  output logic [NREQ-1:0]   tx_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              rx_err,
  input  logic              err_clr,
  output logic              init_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic            armed;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      gap_cnt;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_index;
  logic            arb_any;

  rr_arb #(.N(NREQ), .IW(IW)) u_arb (
    .req   (tx_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .index (arb_index),
    .any   (arb_any)
  );

  // Controller FSM; bus outputs are decoded from the state being entered so
  // they line up with that state's cycle. armed delays the first access one
  // edge so reset itself always shows an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_RST;
      armed     <= 1'b0;
      rr_ptr    <= '0;
      gap_cnt   <= 8'd0;
      acia_cs   <= 1'b0;
      acia_we   <= 1'b0;
      acia_rs   <= 1'b0;
      acia_din  <= 8'h00;
      tx_ready  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      rx_err    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      acia_cs  <= 1'b0;
      acia_we  <= 1'b0;
      acia_rs  <= 1'b0;
      acia_din <= 8'h00;
      tx_ready <= '0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Error set outranks a simultaneous clear.
      if (state == STAT && armed && acia_dout[ST_ERR]) begin
        rx_err <= 1'b1;
      end else if (err_clr) begin
        rx_err <= 1'b0;
      end

      if (!armed) begin
        armed    <= 1'b1;
        state    <= INIT_RST;
        acia_cs  <= 1'b1;
        acia_we  <= 1'b1;
        acia_din <= MRESET;
      end else begin
        case (state)
          INIT_RST: begin
            state     <= INIT_CFG;
            acia_cs   <= 1'b1;
            acia_we   <= 1'b1;
            acia_din  <= CTRL_CFG;
            init_done <= 1'b1;
          end
          INIT_CFG: begin
            state   <= POLL;
            acia_cs <= 1'b1;
          end
          POLL: begin
            state <= STAT;
          end
          STAT: begin
            // A full holding register defers the data read; the ACIA keeps rxf.
            if (acia_dout[ST_RXF] && !rx_valid) begin
              state   <= RX_RD;
              acia_cs <= 1'b1;
              acia_rs <= 1'b1;
            end else if (acia_dout[ST_TXE] && arb_any) begin
              state    <= TX_WR;
              acia_cs  <= 1'b1;
              acia_we  <= 1'b1;
              acia_rs  <= 1'b1;
              acia_din <= tx_data[8*int'(arb_index) +: 8];
              tx_ready <= arb_grant;
              rr_ptr   <= IW'(next_idx(int'(arb_index), NREQ));
            end else begin
              state   <= GAP;
              gap_cnt <= 8'd0;
            end
          end
          RX_RD: begin
            state <= RX_CAP;
          end
          RX_CAP: begin
            rx_data  <= acia_dout;
            rx_valid <= 1'b1;
            state    <= GAP;
            gap_cnt  <= 8'd0;
          end
          TX_WR: begin
            state   <= GAP;
            gap_cnt <= 8'd0;
          end
          GAP: begin
            if (gap_cnt >= 8'(POLL_GAP)) begin
              state   <= POLL;
              acia_cs <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          default: begin
            state <= INIT_RST;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
